csr_ctrl: RTL

Multi-cycle initiator for the machine-mode CSR register file. It accepts one system-instruction request at a time from the execute stage: CSRRW/CSRRS/CSRRC, ECALL or MRET. It then sequences the register file's read, write and trap ports, and returns the old CSR value and any PC redirect. It sits between the EXU and the CSR file, and is the only agent that drives the CSR file's write and trap inputs.

---
 rtl/csr_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/csr_ctrl.sv
// ============================================================================
// csr_ctrl : multi-cycle sequencer between the EXU and the machine-mode CSR
//            file for CSRRW/CSRRS/CSRRC, ECALL and MRET.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module csr_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [11:0]           req_csr_addr,
  input  logic [DATA_WIDTH-1:0] req_src,
  input  logic [DATA_WIDTH-1:0] req_pc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_redirect,
  output logic [DATA_WIDTH-1:0] rsp_npc,
  output logic                  rsp_illegal,
  output logic [DATA_WIDTH-1:0] csr_addr,
  output logic                  csr_wen,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  intr,
  output logic [DATA_WIDTH-1:0] intr_NO,
  output logic [DATA_WIDTH-1:0] intr_epc,
  input  logic [DATA_WIDTH-1:0] intr_mtvec
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_WR      = 3'd2,
    S_TRAP    = 3'd3,
    S_MRD_EPC = 3'd4,
    S_MRD_ST  = 3'd5,
    S_MWR_ST  = 3'd6,
    S_RESP    = 3'd7
  } state_t;

  localparam logic [2:0] c_OP_RW    = 3'd1;
  localparam logic [2:0] c_OP_RS    = 3'd2;
  localparam logic [2:0] c_OP_RC    = 3'd3;
  localparam logic [2:0] c_OP_ECALL = 3'd4;
  localparam logic [2:0] c_OP_MRET  = 3'd5;

  localparam logic [DATA_WIDTH-1:0] c_MSTATUS   = DATA_WIDTH'(12'h300);
  localparam logic [DATA_WIDTH-1:0] c_MEPC      = DATA_WIDTH'(12'h341);
  localparam logic [DATA_WIDTH-1:0] c_ECALL_NO  = DATA_WIDTH'(11);

  state_t                r_state;
  logic [2:0]            r_op;
  logic [DATA_WIDTH-1:0] r_src;
  logic [DATA_WIDTH-1:0] r_old;
  logic [DATA_WIDTH-1:0] r_npc;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_redirect;
  logic [DATA_WIDTH-1:0] r_rsp_npc;
  logic                  r_rsp_illegal;
  logic [DATA_WIDTH-1:0] r_csr_addr;
  logic                  r_csr_wen;
  logic [DATA_WIDTH-1:0] r_csr_wdata;
  logic                  r_intr;
  logic [DATA_WIDTH-1:0] r_intr_no;
  logic [DATA_WIDTH-1:0] r_intr_epc;

  logic                  w_supported;
  logic                  w_csr_op;
  logic                  w_skip_write;
  logic [DATA_WIDTH-1:0] w_req_addr;
  logic [DATA_WIDTH-1:0] w_rmw_data;
  logic [DATA_WIDTH-1:0] w_mret_st;

  assign w_req_addr   = {{(DATA_WIDTH-12){1'b0}}, req_csr_addr};
  assign w_supported  = (req_csr_addr == 12'h300) || (req_csr_addr == 12'h305) ||
                        (req_csr_addr == 12'h341) || (req_csr_addr == 12'h342);
  assign w_csr_op     = (req_op == c_OP_RW) || (req_op == c_OP_RS) || (req_op == c_OP_RC);
  assign w_skip_write = ((r_op == c_OP_RS) || (r_op == c_OP_RC)) && (r_src == '0);

  always_comb begin
    w_rmw_data = r_src;
    if (r_op == c_OP_RS) w_rmw_data = csr_rdata | r_src;
    else if (r_op == c_OP_RC) w_rmw_data = csr_rdata & ~r_src;
  end

  // MRET: restore MIE from MPIE, set MPIE, leave MPP at M-mode.
  always_comb begin
    w_mret_st        = csr_rdata;
    w_mret_st[3]     = csr_rdata[7];
    w_mret_st[7]     = 1'b1;
    w_mret_st[12:11] = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_src          <= '0;
      r_old          <= '0;
      r_npc          <= '0;
      r_req_ready    <= 1'b1;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
      r_rsp_redirect <= 1'b0;
      r_rsp_npc      <= '0;
      r_rsp_illegal  <= 1'b0;
      r_csr_addr     <= '0;
      r_csr_wen      <= 1'b0;
      r_csr_wdata    <= '0;
      r_intr         <= 1'b0;
      r_intr_no      <= '0;
      r_intr_epc     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_src       <= req_src;
            r_req_ready <= 1'b0;
            if (w_csr_op && w_supported) begin
              r_csr_addr <= w_req_addr;
              r_state    <= S_RD;
            end else if (req_op == c_OP_ECALL) begin
              r_intr     <= 1'b1;
              r_intr_no  <= c_ECALL_NO;
              r_intr_epc <= req_pc;
              r_state    <= S_TRAP;
            end else if (req_op == c_OP_MRET) begin
              r_csr_addr <= c_MEPC;
              r_state    <= S_MRD_EPC;
            end else begin
              r_rsp_valid   <= 1'b1;
              r_rsp_illegal <= 1'b1;
              r_state       <= S_RESP;
            end
          end
        end
        S_RD: begin
          r_old <= csr_rdata;
          if (w_skip_write) begin
            r_csr_addr  <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= csr_rdata;
            r_state     <= S_RESP;
          end else begin
            r_csr_wen   <= 1'b1;
            r_csr_wdata <= w_rmw_data;
            r_state     <= S_WR;
          end
        end
        S_WR: begin
          r_csr_wen   <= 1'b0;
          r_csr_addr  <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_old;
          r_state     <= S_RESP;
        end
        S_TRAP: begin
          r_intr         <= 1'b0;
          r_rsp_valid    <= 1'b1;
          r_rsp_redirect <= 1'b1;
          r_rsp_npc      <= intr_mtvec;
          r_state        <= S_RESP;
        end
        S_MRD_EPC: begin
          r_npc      <= csr_rdata;
          r_csr_addr <= c_MSTATUS;
          r_state    <= S_MRD_ST;
        end
        S_MRD_ST: begin
          r_csr_wen   <= 1'b1;
          r_csr_wdata <= w_mret_st;
          r_state     <= S_MWR_ST;
        end
        S_MWR_ST: begin
          r_csr_wen      <= 1'b0;
          r_csr_addr     <= '0;
          r_rsp_valid    <= 1'b1;
          r_rsp_redirect <= 1'b1;
          r_rsp_npc      <= r_npc;
          r_state        <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_redirect <= 1'b0;
            r_rsp_npc      <= '0;
            r_rsp_illegal  <= 1'b0;
            r_req_ready    <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_redirect = r_rsp_redirect;
  assign rsp_npc      = r_rsp_npc;
  assign rsp_illegal  = r_rsp_illegal;
  assign csr_addr     = r_csr_addr;
  assign csr_wen      = r_csr_wen;
  assign csr_wdata    = r_csr_wdata;
  assign intr         = r_intr;
  assign intr_NO      = r_intr_no;
  assign intr_epc     = r_intr_epc;

endmodule

`default_nettype wire
